// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access master.
// Holds the request type codes, the FSM state encoding, the default
// timeout/limit values and a legality helper used by the top level.
package dm_pkg;

  // Load request types
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_HU = 3'b010;
  localparam logic [2:0] LD_B  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;

  // Store request types
  localparam logic [2:0] ST_W  = 3'b000;
  localparam logic [2:0] ST_H  = 3'b001;
  localparam logic [2:0] ST_B  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_TIMEOUT    = 16;
  localparam logic [31:0] DEF_ADDR_LIMIT = 32'h0000_3FFF;

  // An access is legal when it is in range, naturally aligned for its
  // size, and uses a type code that exists for its direction.
  function automatic logic access_legal(input logic        we,
                                        input logic [2:0]  rtype,
                                        input logic [31:0] addr,
                                        input logic [31:0] limit);
    logic ok;
    ok = (addr <= limit);
    if (we) begin
      case (rtype)
        ST_W:    ok = ok & (addr[1:0] == 2'b00);
        ST_H:    ok = ok & ~addr[0];
        ST_B:    ok = ok;
        default: ok = 1'b0;
      endcase
    end else begin
      case (rtype)
        LD_W:        ok = ok & (addr[1:0] == 2'b00);
        LD_H, LD_HU: ok = ok & ~addr[0];
        LD_B, LD_BU: ok = ok;
        default:     ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/dm_load_extend.sv
// Load data formatter: picks the addressed half/byte out of a full bus
// word and sign- or zero-extends it to 32 bits.
// Ports:
//   word      - full 32-bit word returned by the bus
//   offset    - byte offset within the word (addr[1:0])
//   load_type - load type code (LD_*)
//   data      - extended result (0 for an unknown type)
module dm_load_extend
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase

    data = '0;
    case (load_type)
      LD_W:    data = word;
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data = {16'h0000, half_sel};
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'h000000, byte_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_access_master.sv
// Memory-stage initiator for the data-memory port. Takes one load/store
// from the M stage, rejects misaligned/out-of-range/unknown accesses,
// issues a word-addressed byte-enabled req/ack bus transaction, and
// returns extended load data while stalling the pipeline.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   req_valid/we/type/addr/wdata - request from the M stage
//   stall                   - combinational pipeline freeze
//   rdata, rdata_valid      - result and one-cycle completion strobe
//   addr_err, bus_err       - one-cycle error pulses (illegal / timeout)
//   bus_req/we/addr/be/wdata - registered bus request
//   bus_ack, bus_rdata      - responder completion and read word
module dm_access_master
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter logic [31:0] ADDR_LIMIT = DEF_ADDR_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int             CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       type_reg;
  logic [1:0]       offset_reg;
  logic             we_reg;

  logic             legal;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;
  logic [31:0]      load_data;

  assign legal = access_legal(req_we, req_type, req_addr, ADDR_LIMIT);

  // Reset forces stall low so the pipeline is released immediately.
  assign stall = req_valid & ~reset & (state_reg != S_DONE);

  // Lane placement: byte enables follow the access size and offset;
  // narrow store data is replicated across every lane.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    if (req_we) begin
      case (req_type)
        ST_H: begin
          be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{req_wdata[15:0]}};
        end
        ST_B: begin
          be_next    = 4'b0001 << req_addr[1:0];
          wdata_next = {4{req_wdata[7:0]}};
        end
        default: ;
      endcase
    end else begin
      wdata_next = '0;
      case (req_type)
        LD_H, LD_HU: be_next = req_addr[1] ? 4'b1100 : 4'b0011;
        LD_B, LD_BU: be_next = 4'b0001 << req_addr[1:0];
        default:     be_next = 4'b1111;
      endcase
    end
  end

  // Extraction works from the latched type/offset so that the M stage
  // may change req_* while the bus access is outstanding.
  dm_load_extend u_load_extend (
    .word      (bus_rdata),
    .offset    (offset_reg),
    .load_type (type_reg),
    .data      (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      type_reg    <= '0;
      offset_reg  <= '0;
      we_reg      <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      bus_err     <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            if (legal) begin
              type_reg   <= req_type;
              offset_reg <= req_addr[1:0];
              we_reg     <= req_we;
              bus_req    <= 1'b1;
              bus_we     <= req_we;
              bus_addr   <= req_addr[31:2];
              bus_be     <= be_next;
              bus_wdata  <= wdata_next;
              cnt_reg    <= '0;
              state_reg  <= S_WAIT;
            end else begin
              // Illegal access: complete without touching the bus.
              rdata       <= '0;
              rdata_valid <= 1'b1;
              addr_err    <= 1'b1;
              state_reg   <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          // Ack is tested first so it wins over a simultaneous timeout.
          if (bus_ack) begin
            bus_req     <= 1'b0;
            rdata       <= we_reg ? 32'h0 : load_data;
            rdata_valid <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= S_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            bus_req     <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b1;
            bus_err     <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_DONE: begin
          rdata       <= '0;
          rdata_valid <= 1'b0;
          addr_err    <= 1'b0;
          bus_err     <= 1'b0;
          state_reg   <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_master.sv
module tb_dm_access_master;

  localparam int          TMO   = 16;
  localparam logic [31:0] LIMIT = 32'h0000_3FFF;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        addr_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  dm_access_master #(.TIMEOUT(TMO), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .addr_err(addr_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_size(input bit we, input int t);
    if (we) return (t == 0) ? 4 : (t == 1) ? 2 : (t == 2) ? 1 : 0;
    else    return (t == 0) ? 4 : (t <= 2) ? 2 : (t <= 4) ? 1 : 0;
  endfunction

  function automatic bit m_legal(input bit we, input int t, input logic [31:0] a);
    int s;
    s = m_size(we, t);
    if (s == 0) return 0;
    if (a > LIMIT) return 0;
    return (a % s) == 0;
  endfunction

  function automatic logic [3:0] m_be(input bit we, input int t, input logic [31:0] a);
    int v;
    v = ((1 << m_size(we, t)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int t, input logic [31:0] w);
    case (m_size(1'b1, t))
      2:       return (w & 32'h0000FFFF) * 32'h00010001;
      1:       return (w & 32'h000000FF) * 32'h01010101;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input int t, input logic [31:0] a, input logic [31:0] word);
    int s;
    logic [31:0] mask, v;
    s = m_size(1'b0, t);
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
    v = (word >> ((a % 4) * 8)) & mask;
    if ((t == 1 || t == 3) && (((v >> (8 * s - 1)) & 32'd1) == 32'd1)) v = v | ~mask;
    return v;
  endfunction

  // ---------------- access driver (observes only) ----------------
  int          o_done_cyc, o_req_cycles, o_stall_cycles;
  bit          o_stall_at_done, o_stable, o_pulse_ok;
  logic        o_bus_we;
  logic [29:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata, o_rdata;
  logic        o_aerr, o_berr;

  // d = number of bus_req cycles before ack (0 = ack in first), -1 = never
  task automatic run_access(input bit we, input int t, input logic [31:0] a,
                            input logic [31:0] w, input logic [31:0] rw,
                            input int d, input bit keep);
    int  cyc;
    bit  done;
    logic [31:0] scr;
    o_done_cyc = -1; o_req_cycles = 0; o_stall_cycles = 0;
    o_stall_at_done = 1'b1; o_stable = 1'b1; o_pulse_ok = 1'b1;
    o_bus_we = 1'bx; o_bus_addr = 'x; o_bus_be = 'x; o_bus_wdata = 'x;
    o_rdata = 'x; o_aerr = 1'bx; o_berr = 1'bx;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_type = t[2:0];
    req_addr = a; req_wdata = w; bus_rdata = rw; bus_ack = 1'b0;
    cyc = 1; done = 1'b0;
    while (!done && cyc <= 40) begin
      #1;
      if (rdata_valid) begin
        done = 1'b1;
        o_done_cyc = cyc; o_rdata = rdata; o_aerr = addr_err; o_berr = bus_err;
        o_stall_at_done = stall;
      end else begin
        if (stall) o_stall_cycles++;
        if (bus_req) begin
          o_req_cycles++;
          if (o_req_cycles == 1) begin
            o_bus_we = bus_we; o_bus_addr = bus_addr; o_bus_be = bus_be; o_bus_wdata = bus_wdata;
          end else if (bus_we !== o_bus_we || bus_addr !== o_bus_addr ||
                       bus_be !== o_bus_be || bus_wdata !== o_bus_wdata) begin
            o_stable = 1'b0;
          end
        end
        bus_ack = bus_req && (d >= 0) && (o_req_cycles == d + 1);
        if (cyc >= 2) begin
          // request is already latched; scramble to prove it is ignored
          scr = $urandom; req_addr = scr;
          req_wdata = $urandom; req_type = scr[2:0]; req_we = scr[3];
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus_ack = 1'b0;
    if (!keep) begin
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      o_pulse_ok = !rdata_valid && !addr_err && !bus_err && !bus_req;
    end
    $display("txn we=%0d type=%0d addr=%08h wdata=%08h rword=%08h ack_after=%0d -> done_cyc=%0d req_cycles=%0d rdata=%08h aerr=%0d berr=%0d",
             we, t, a, w, rw, d, o_done_cyc, o_req_cycles, o_rdata, o_aerr, o_berr);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_type = 3'd0;
    req_addr = 32'h10; req_wdata = 32'h0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    checks++;
    if ({rdata_valid, addr_err, bus_err, bus_req, bus_we} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %05b expected 00000", {rdata_valid, addr_err, bus_err, bus_req, bus_we});
    end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %08h expected 00000000", rdata); end
    checks++;
    if ({bus_addr, bus_be, bus_wdata} !== 66'h0) begin
      errors++; $display("FAIL reset_bus: got addr=%08h be=%0h wdata=%08h expected zeros", bus_addr, bus_be, bus_wdata);
    end
    checks++;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0; bus_ack = 1'b0;
  endtask

  typedef struct {
    bit          we;
    int          t;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] rw;
    int          d;
  } case_t;

  task automatic test_directed;
    case_t tbl[$];
    case_t c;
    bit legal;
    int exp_done, exp_req;
    logic [31:0] exp_rdata;
    string tag;
    tbl.push_back('{1'b1, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0});
    tbl.push_back('{1'b1, 2, 32'h13,   32'h000000A5, 32'h0,        1});
    tbl.push_back('{1'b1, 1, 32'h22,   32'h00001234, 32'h0,        2});
    tbl.push_back('{1'b0, 3, 32'h21,   32'h0,        32'h80F17F01, 0});
    tbl.push_back('{1'b0, 3, 32'h23,   32'h0,        32'h80F17F01, 1});
    tbl.push_back('{1'b0, 4, 32'h23,   32'h0,        32'h80F17F01, 0});
    tbl.push_back('{1'b0, 1, 32'h22,   32'h0,        32'h80F17F01, 3});
    tbl.push_back('{1'b0, 2, 32'h20,   32'h0,        32'h80F17F01, 0});
    tbl.push_back('{1'b0, 0, 32'h20,   32'h0,        32'h80F17F01, 0});
    tbl.push_back('{1'b0, 0, 32'h6,    32'h0,        32'h12345678, 0});
    tbl.push_back('{1'b1, 0, 32'h4000, 32'h11111111, 32'h0,        0});
    tbl.push_back('{1'b0, 5, 32'h0,    32'h0,        32'h12345678, 0});
    tbl.push_back('{1'b1, 3, 32'h0,    32'h22222222, 32'h0,        0});
    tbl.push_back('{1'b0, 1, 32'h21,   32'h0,        32'h12345678, 0});
    tbl.push_back('{1'b0, 0, 32'h3FFC, 32'h0,        32'hCAFEF00D, 0});
    tbl.push_back('{1'b1, 2, 32'h3FFF, 32'h0000005A, 32'h0,        0});
    tbl.push_back('{1'b0, 0, 32'h40,   32'h0,        32'h0BADC0DE, -1});
    tbl.push_back('{1'b0, 4, 32'h41,   32'h0,        32'hA5C3E1F0, 15});
    foreach (tbl[i]) begin
      c = tbl[i];
      tag = $sformatf("dir%0d", i);
      run_access(c.we, c.t, c.a, c.w, c.rw, c.d, 1'b0);
      legal     = m_legal(c.we, c.t, c.a);
      exp_done  = !legal ? 2 : (c.d < 0) ? TMO + 2 : c.d + 3;
      exp_req   = !legal ? 0 : (c.d < 0) ? TMO : c.d + 1;
      exp_rdata = (!legal || c.we || c.d < 0) ? 32'h0 : m_load(c.t, c.a, c.rw);
      if (o_done_cyc !== exp_done) begin errors++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, o_done_cyc, exp_done); end
      checks++;
      if (o_req_cycles !== exp_req) begin errors++; $display("FAIL %s req_cycles: got %0d expected %0d", tag, o_req_cycles, exp_req); end
      checks++;
      if (o_stall_cycles !== exp_done - 1) begin errors++; $display("FAIL %s stall_cycles: got %0d expected %0d", tag, o_stall_cycles, exp_done - 1); end
      checks++;
      if (o_stall_at_done !== 1'b0) begin errors++; $display("FAIL %s stall_at_done: got %0b expected 0", tag, o_stall_at_done); end
      checks++;
      if (o_rdata !== exp_rdata) begin errors++; $display("FAIL %s rdata: got %08h expected %08h", tag, o_rdata, exp_rdata); end
      checks++;
      if ({o_aerr, o_berr} !== {!legal, legal && c.d < 0}) begin
        errors++; $display("FAIL %s errs: got aerr=%0b berr=%0b expected aerr=%0b berr=%0b", tag, o_aerr, o_berr, !legal, legal && c.d < 0);
      end
      checks++;
      if (o_pulse_ok !== 1'b1) begin errors++; $display("FAIL %s one_cycle_pulse: got %0b expected 1", tag, o_pulse_ok); end
      checks++;
      if (legal) begin
        if (o_bus_addr !== c.a[31:2] || o_bus_we !== c.we || o_stable !== 1'b1) begin
          errors++; $display("FAIL %s bus_addr_we: got addr=%08h we=%0b stable=%0b expected addr=%08h we=%0b stable=1", tag, o_bus_addr, o_bus_we, o_stable, c.a[31:2], c.we);
        end
        checks++;
        if (c.we) begin
          if (o_bus_be !== m_be(c.we, c.t, c.a) || o_bus_wdata !== m_wdata(c.t, c.w)) begin
            errors++; $display("FAIL %s store_lanes: got be=%04b wdata=%08h expected be=%04b wdata=%08h", tag, o_bus_be, o_bus_wdata, m_be(c.we, c.t, c.a), m_wdata(c.t, c.w));
          end
          checks++;
        end
      end
    end
  endtask

  task automatic test_random;
    bit we, legal;
    int t, d, r;
    logic [31:0] a, w, rw, exp_rdata;
    int exp_done;
    for (int i = 0; i < 120; i++) begin
      we = $urandom_range(0, 1);
      t  = we ? $urandom_range(0, 3) : $urandom_range(0, 5);
      r  = $urandom_range(0, 9);
      a  = (r == 0) ? $urandom_range(32'h3FF8, 32'h4010) : $urandom_range(0, 32'h3FFF);
      if (r < 5) a = a & 32'hFFFF_FFFC;
      r  = $urandom_range(0, 19);
      d  = (r == 0) ? -1 : (r == 1) ? TMO - 1 : $urandom_range(0, 3);
      w  = $urandom; rw = $urandom;
      run_access(we, t, a, w, rw, d, 1'b0);
      legal     = m_legal(we, t, a);
      exp_done  = !legal ? 2 : (d < 0) ? TMO + 2 : d + 3;
      exp_rdata = (!legal || we || d < 0) ? 32'h0 : m_load(t, a, rw);
      if (o_done_cyc !== exp_done || o_stall_cycles !== exp_done - 1) begin
        errors++; $display("FAIL rnd%0d timing: got done=%0d stalls=%0d expected done=%0d stalls=%0d", i, o_done_cyc, o_stall_cycles, exp_done, exp_done - 1);
      end
      checks++;
      if (o_rdata !== exp_rdata || o_aerr !== !legal || o_berr !== (legal && d < 0)) begin
        errors++; $display("FAIL rnd%0d result: got rdata=%08h aerr=%0b berr=%0b expected rdata=%08h aerr=%0b berr=%0b", i, o_rdata, o_aerr, o_berr, exp_rdata, !legal, legal && d < 0);
      end
      checks++;
      if (legal && (o_bus_addr !== a[31:2] || o_stable !== 1'b1 ||
                    (we && (o_bus_be !== m_be(we, t, a) || o_bus_wdata !== m_wdata(t, w))))) begin
        errors++; $display("FAIL rnd%0d bus: got addr=%08h be=%04b wdata=%08h stable=%0b", i, o_bus_addr, o_bus_be, o_bus_wdata, o_stable);
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rw;
    for (int i = 0; i < 4; i++) begin
      rw = $urandom;
      run_access(1'b0, 0, 32'h100 + 4 * i, 32'h0, rw, i % 2, (i != 3));
      if (o_done_cyc !== (i % 2) + 3 || o_rdata !== rw) begin
        errors++; $display("FAIL b2b%0d: got done=%0d rdata=%08h expected done=%0d rdata=%08h", i, o_done_cyc, o_rdata, (i % 2) + 3, rw);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rw;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'd0; req_addr = 32'h80;
    bus_ack = 1'b0; bus_rdata = 32'h55AA55AA;
    repeat (3) @(negedge clk);
    #1;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL midreset_pre_req: got %0b expected 1", bus_req); end
    checks++;
    #2 reset = 1'b1;
    #1;
    if (bus_req !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_async: got req=%0b stall=%0b rvalid=%0b expected 0 0 0", bus_req, stall, rdata_valid);
    end
    checks++;
    bus_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    if (rdata_valid !== 1'b0 || bus_req !== 1'b0) begin
      errors++; $display("FAIL midreset_ack_ignored: got rvalid=%0b req=%0b expected 0 0", rdata_valid, bus_req);
    end
    checks++;
    @(negedge clk);
    #1;
    if (rdata_valid !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet: got rvalid=%0b berr=%0b expected 0 0", rdata_valid, bus_err);
    end
    checks++;
    bus_ack = 1'b0;
    rw = $urandom;
    run_access(1'b0, 0, 32'h84, 32'h0, rw, 0, 1'b0);
    if (o_done_cyc !== 3 || o_rdata !== rw || o_berr !== 1'b0) begin
      errors++; $display("FAIL midreset_recover: got done=%0d rdata=%08h berr=%0b expected done=3 rdata=%08h berr=0", o_done_cyc, o_rdata, o_berr, rw);
    end
    checks++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_mid_wait;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_access_master.md
Name: dm_access_master

Overview:
Memory-stage initiator that drives the data-memory port on behalf of the pipeline.
- Accepts one load/store request from the M stage.
- Checks alignment and range.
- Converts the request into a word-addressed, byte-enabled bus transaction with a req/ack handshake.
- Returns sign/zero-extended load data and stalls the pipeline until the access completes.

Parameters:
TIMEOUT, 16, cycles waiting for bus_ack before the access is aborted with bus_err.
ADDR_LIMIT, 32'h0000_3FFF, highest legal byte address (4096 words).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  M-stage access present
req_we  input  1  1 = store, 0 = load
req_type  input  3  load: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; store: 000 sw, 001 sh, 010 sb
req_addr  input  32  byte address
req_wdata  input  32  store data, unaligned in the low bits
stall  output  1  freeze pipeline (combinational)
rdata  output  32  extended load result
rdata_valid  output  1  one-cycle completion strobe
addr_err  output  1  misaligned or out-of-range access
bus_err  output  1  timeout abort
bus_req  output  1  transaction request (registered)
bus_we  output  1  write
bus_addr  output  30  word address (req_addr[31:2])
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated write data
bus_ack  input  1  responder completion
bus_rdata  input  32  full read word

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE immediately; the counter clears.
  - All outputs are 0, including bus_req. This is immediate even mid-transaction.
  - Any in-flight ack after reset is ignored.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If req_valid and the access is legal, latch the request and go to WAIT.
  - On the next edge, bus_req=1 and bus_we/addr/be/wdata are valid.
  - If req_valid and the access is illegal, no bus transaction is issued; go to DONE with addr_err=1.
- Illegality:
  - Word access with addr[1:0]!=0, or half access with addr[0]!=0.
  - addr > ADDR_LIMIT.
  - req_type > 100 for a load, or > 010 for a store.
- WAIT:
  - Bus outputs are held stable.
  - The counter increments each cycle.
  - On bus_ack: capture the extended bus_rdata (loads), drop bus_req, go to DONE.
  - When the counter reaches TIMEOUT-1 without ack: drop bus_req, go to DONE with bus_err=1.
  - If ack and timeout occur in the same cycle, ack wins and bus_err=0.
- DONE:
  - rdata_valid=1 for this cycle only. rdata holds the result (0 for stores and errors).
  - addr_err/bus_err are asserted this cycle only.
  - Next state is IDLE.
- stall = req_valid & (state != DONE).
  - With a zero-wait responder (ack in the first bus_req cycle), stall lasts 2 cycles and rdata_valid arrives on the 3rd.
  - Back-to-back requests re-enter WAIT after one IDLE cycle.
- Store lanes:
  - sw: be=1111.
  - sh: be=0011 (addr[1]=0) or 1100; wdata={2{wdata[15:0]}}.
  - sb: be=0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
- Load extract:
  - Select the half by addr[1] and the byte by addr[1:0].
  - Sign-extend for lh/lb, zero-extend for lhu/lbu.
- A change of req_* while in WAIT is ignored (the latched copy is used).

Decomposition:
- Package dm_pkg:
  - req_type codes (LD_W, LD_H, LD_HU, LD_B, LD_BU, ST_W, ST_H, ST_B).
  - State encoding.
  - Default TIMEOUT and ADDR_LIMIT.
- Sub-module dm_load_extend: combinational lane select plus sign/zero extension (bus_rdata, addr[1:0], type -> 32-bit).

Test Plan:
- sw addr 0x10 data 0xDEADBEEF, ack in the first req cycle -> bus_addr=0x4, be=1111, wdata=0xDEADBEEF; stall 2 cycles; rdata_valid on cycle 3.
- sb addr 0x13 data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5; sh addr 0x22 data 0x1234 -> be=1100, wdata=0x12341234.
- bus_rdata 0x80F17F01 at word 0x20:
  - lb addr 0x21 -> 0x0000007F.
  - lb addr 0x23 -> 0xFFFFFF80.
  - lbu addr 0x23 -> 0x00000080.
  - lh addr 0x22 -> 0xFFFF80F1.
  - lhu addr 0x20 -> 0x00007F01.
- lw addr 0x6, and sw addr 0x4000 -> no bus_req ever; addr_err=1 and rdata_valid=1 together for one cycle; rdata=0.
- Ack withheld -> bus_req drops after 16 cycles, bus_err pulse, stall released; ack on exactly cycle 16 -> normal completion, bus_err=0.
- reset asserted mid-WAIT -> bus_req and stall go to 0 asynchronously; after release the next request completes normally.
